// File: rtl/mem_access_unit_pkg.sv
// Shared bus widths, enable levels, size/error/state codes and store-side helpers
// for the load/store memory access unit.
package mem_access_unit_pkg;

  localparam int WORD_ADDR_W = 32;
  localparam int WORD_DATA_W = 32;
  localparam int WEA_W       = 4;

  typedef logic [WORD_ADDR_W-1:0] word_addr_t;
  typedef logic [WORD_DATA_W-1:0] word_data_t;
  typedef logic [WEA_W-1:0]       wea_t;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_RANGE    = 2'b10,
    ERR_SIZE     = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_ERR   = 2'b11
  } state_e;

  // Error priority: bad size, then misaligned, then out of range.
  function automatic err_e access_err(input logic [1:0] size, input word_addr_t addr,
                                      input int unsigned addr_msb);
    err_e err_v;
    logic misaligned_v;
    misaligned_v = 1'b0;
    case (size)
      SIZE_HALF: misaligned_v = addr[0];
      SIZE_WORD: misaligned_v = (addr[1:0] != 2'b00);
      default:   misaligned_v = 1'b0;
    endcase
    if (size == SIZE_RSVD) begin
      err_v = ERR_SIZE;
    end else if (misaligned_v) begin
      err_v = ERR_MISALIGN;
    end else if ((addr >> (addr_msb + 32'd1)) != 32'd0) begin
      err_v = ERR_RANGE;
    end else begin
      err_v = ERR_OK;
    end
    return err_v;
  endfunction

  function automatic wea_t store_wea(input logic [1:0] size, input logic [1:0] offset);
    wea_t wea_v;
    case (size)
      SIZE_BYTE: wea_v = 4'b0001 << offset;
      SIZE_HALF: wea_v = 4'b0011 << offset;
      SIZE_WORD: wea_v = 4'b1111;
      default:   wea_v = 4'b0000;
    endcase
    return wea_v;
  endfunction

  // Replicate narrow store data so the byte enables alone pick the lane.
  function automatic word_data_t store_lanes(input logic [1:0] size, input word_data_t wdata);
    word_data_t lanes_v;
    case (size)
      SIZE_BYTE: lanes_v = {4{wdata[7:0]}};
      SIZE_HALF: lanes_v = {2{wdata[15:0]}};
      SIZE_WORD: lanes_v = wdata;
      default:   lanes_v = 32'h0000_0000;
    endcase
    return lanes_v;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Combinational load lane select and sign/zero extension (little-endian lanes).
module load_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0] size,
  input  logic       uns,
  input  logic [1:0] offset,
  input  word_data_t word,
  output word_data_t data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  word_data_t  data_s;

  // Pick the addressed lane and extend it to a full word.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    data_s = 32'h0000_0000;
    case (offset)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      2'd3:    byte_s = word[31:24];
      default: byte_s = 8'h00;
    endcase
    if (offset[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
    case (size)
      SIZE_BYTE: begin
        if (uns) begin
          data_s = {24'h00_0000, byte_s};
        end else begin
          data_s = {{24{byte_s[7]}}, byte_s};
        end
      end
      SIZE_HALF: begin
        if (uns) begin
          data_s = {16'h0000, half_s};
        end else begin
          data_s = {{16{half_s[15]}}, half_s};
        end
      end
      SIZE_WORD: data_s = word;
      default:   data_s = 32'h0000_0000;
    endcase
  end

  assign data = data_s;

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: one request at a time, checks size/alignment/range, drives a
// 1-cycle-latency byte-enabled memory port and returns one response pulse.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int MEM_ADDR_MSB = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  word_addr_t       req_addr,
  input  word_data_t       req_wdata,
  output logic             rsp_valid,
  output word_data_t       rsp_rdata,
  output logic [1:0]       rsp_err,
  output word_addr_t       mem_data_addr,
  output word_data_t       mem_data_input,
  output wea_t             mem_data_wea,
  input  word_data_t       mem_data_output
);

  state_e     state_r, state_s;
  logic       accept_s;
  err_e       req_err_s;

  logic       we_r;
  logic [1:0] size_r;
  logic       uns_r;
  logic [1:0] offset_r;
  err_e       err_r;

  word_addr_t mem_addr_r;
  word_data_t mem_wdata_r;
  wea_t       wea_r;

  logic       rsp_valid_r;
  word_data_t rsp_rdata_r;
  err_e       rsp_err_r;
  word_data_t load_data_s;

  assign accept_s  = req_valid & (state_r == ST_IDLE);
  assign req_err_s = access_err(req_size, req_addr, MEM_ADDR_MSB);

  // State register; reset drops any in-flight access without a response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (req_err_s != ERR_OK) begin
            state_s = ST_ERR;
          end else begin
            state_s = ST_ISSUE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (we_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_WAIT: state_s = ST_IDLE;
      ST_ERR:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  load_align u_load_align (
    .size   (size_r),
    .uns    (uns_r),
    .offset (offset_r),
    .word   (mem_data_output),
    .data   (load_data_s)
  );

  // Request latch, memory port drive and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_r        <= DISABLE;
      size_r      <= SIZE_BYTE;
      uns_r       <= DISABLE;
      offset_r    <= 2'b00;
      err_r       <= ERR_OK;
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
      wea_r       <= 4'b0000;
      rsp_valid_r <= DISABLE;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= ERR_OK;
    end else begin
      rsp_valid_r <= DISABLE;
      wea_r       <= 4'b0000;
      if (accept_s) begin
        we_r     <= req_we;
        size_r   <= req_size;
        uns_r    <= req_unsigned;
        offset_r <= req_addr[1:0];
        err_r    <= req_err_s;
        if (req_err_s == ERR_OK) begin
          mem_addr_r  <= {req_addr[31:2], 2'b00};
          mem_wdata_r <= store_lanes(req_size, req_wdata);
          if (req_we) begin
            wea_r <= store_wea(req_size, req_addr[1:0]);
          end
        end
      end
      case (state_r)
        ST_ISSUE: begin
          if (we_r) begin
            rsp_valid_r <= ENABLE;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= ERR_OK;
          end
        end
        ST_WAIT: begin
          rsp_valid_r <= ENABLE;
          rsp_rdata_r <= load_data_s;
          rsp_err_r   <= ERR_OK;
        end
        ST_ERR: begin
          rsp_valid_r <= ENABLE;
          rsp_rdata_r <= 32'h0000_0000;
          rsp_err_r   <= err_r;
        end
        default: begin
        end
      endcase
    end
  end

  assign req_ready      = (state_r == ST_IDLE);
  assign rsp_valid      = rsp_valid_r;
  assign rsp_rdata      = rsp_rdata_r;
  assign rsp_err        = rsp_err_r;
  assign mem_data_addr  = mem_addr_r;
  assign mem_data_input = mem_wdata_r;
  assign mem_data_wea   = wea_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 1-cycle-latency byte-enabled memory
// model and a response scoreboard.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [31:0] mem_data_addr;
  logic [31:0] mem_data_input;
  logic [3:0]  mem_data_wea;
  logic [31:0] mem_data_output;

  int errors;
  int checks;
  int rsp_count;
  int push_count;
  logic [33:0] sb[$];

  logic        mem_init;
  logic [31:0] mem [0:255];

  mem_access_unit #(.MEM_ADDR_MSB(17)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_size        (req_size),
    .req_unsigned    (req_unsigned),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .rsp_err         (rsp_err),
    .mem_data_addr   (mem_data_addr),
    .mem_data_input  (mem_data_input),
    .mem_data_wea    (mem_data_wea),
    .mem_data_output (mem_data_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: synchronous read (old data), byte-enabled write.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem_data_output <= 32'h0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (mem_data_wea[b]) mem[mem_data_addr[9:2]][8*b +: 8] <= mem_data_input[8*b +: 8];
      mem_data_output <= mem[mem_data_addr[9:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every response must match the oldest expected entry.
  always @(negedge clk) begin
    logic [33:0] exp_v;
    if (rst === 1'b1 && rsp_valid === 1'b1) begin
      rsp_count++;
      exp_v = 34'h3_FFFF_FFFF;
      if (sb.size() != 0) exp_v = sb.pop_front();
      chk("rsp_rdata", rsp_rdata, exp_v[33:2]);
      chk("rsp_err", {30'd0, rsp_err}, {30'd0, exp_v[1:0]});
    end
  end

  task automatic push_exp(input logic [31:0] rdata, input logic [1:0] err);
    sb.push_back({rdata, err});
    push_count++;
  endtask

  task automatic req(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic [1:0] exp_err,
                     input logic [3:0] exp_wea, input logic [31:0] exp_wdata,
                     input int exp_lat);
    int lat;
    logic got;
    logic [3:0] wea_or;
    int wea_cyc;
    @(negedge clk);
    chk("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    push_exp(exp_rdata, exp_err);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = ~we; req_size = 2'b11; req_unsigned = ~uns;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0;
    lat = 0; got = 1'b0; wea_or = 4'b0000; wea_cyc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0 && exp_err == 2'b00) chk("mem_addr", mem_data_addr, {addr[31:2], 2'b00});
      if (mem_data_wea !== 4'b0000) begin
        wea_or = wea_or | mem_data_wea;
        wea_cyc++;
        chk("mem_wdata", mem_data_input, exp_wdata);
      end
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
        lat = i;
        break;
      end
    end
    chk("rsp_seen", {31'd0, got}, 32'd1);
    chk("latency", lat, exp_lat);
    chk("wea_value", {28'd0, wea_or}, {28'd0, exp_wea});
    chk("wea_cycles", wea_cyc, (exp_wea != 4'b0000) ? 1 : 0);
    @(negedge clk);
    chk("rsp_pulse", {31'd0, rsp_valid}, 32'd0);
    chk("rsp_hold", rsp_rdata, exp_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int rc0;
    errors = 0; checks = 0; rsp_count = 0; push_count = 0;
    rst = 1'b0; mem_init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", {30'd0, rsp_err}, 32'd0);
    chk("rst_addr", mem_data_addr, 32'h0);
    chk("rst_input", mem_data_input, 32'h0);
    chk("rst_wea", {28'd0, mem_data_wea}, 32'd0);
    mem_init = 1'b0;
    rst = 1'b1;

    // we, size, uns, addr, wdata, exp_rdata, exp_err, exp_wea, exp_wdata, exp_lat
    req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 2'b00, 4'b1111, 32'hDEADBEEF, 1);
    req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 2'b00, 4'b0000, 32'h0, 2);
    req(1'b1, 2'b00, 1'b0, 32'h103, 32'h80, 32'h0, 2'b00, 4'b1000, 32'h80808080, 1);
    req(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'hFFFFFF80, 2'b00, 4'b0000, 32'h0, 2);
    req(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h00000080, 2'b00, 4'b0000, 32'h0, 2);
    req(1'b1, 2'b01, 1'b0, 32'h102, 32'h8001, 32'h0, 2'b00, 4'b1100, 32'h80018001, 1);
    req(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'hFFFF8001, 2'b00, 4'b0000, 32'h0, 2);
    req(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 32'h0000BEEF, 2'b00, 4'b0000, 32'h0, 2);
    req(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'hFFFFFFBE, 2'b00, 4'b0000, 32'h0, 2);
    req(1'b1, 2'b01, 1'b0, 32'h101, 32'h1234, 32'h0, 2'b01, 4'b0000, 32'h0, 1);
    req(1'b0, 2'b10, 1'b0, 32'h40000, 32'h0, 32'h0, 2'b10, 4'b0000, 32'h0, 1);
    req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 2'b11, 4'b0000, 32'h0, 1);
    req(1'b1, 2'b11, 1'b0, 32'h1, 32'h55, 32'h0, 2'b11, 4'b0000, 32'h0, 1);
    req(1'b0, 2'b10, 1'b0, 32'h40002, 32'h0, 32'h0, 2'b01, 4'b0000, 32'h0, 1);
    req(1'b0, 2'b01, 1'b0, 32'h3FFFE, 32'h0, 32'h0, 2'b00, 4'b0000, 32'h0, 2);
    req(1'b1, 2'b00, 1'b0, 32'h101, 32'hFFFFFF5A, 32'h0, 2'b00, 4'b0010, 32'h5A5A5A5A, 1);
    req(1'b0, 2'b10, 1'b1, 32'h100, 32'h0, 32'h80015AEF, 2'b00, 4'b0000, 32'h0, 2);

    // Back-to-back store then load with req_valid held high.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h200; req_wdata = 32'h11223344;
    push_exp(32'h0, 2'b00);
    push_exp(32'h11223344, 2'b00);
    @(posedge clk);
    #1;
    req_we = 1'b0; req_unsigned = 1'b1; req_wdata = 32'h0;
    @(negedge clk);
    chk("b2b_busy", {31'd0, req_ready}, 32'd0);
    chk("b2b_wea", {28'd0, mem_data_wea}, 32'hF);
    @(negedge clk);
    chk("b2b_rsp1", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_ready_in_rsp", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_second_busy", {31'd0, req_ready}, 32'd0);
    chk("b2b_no_dup", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("b2b_wait", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("b2b_rsp2", {31'd0, rsp_valid}, 32'd1);

    // Reset while a store is in ISSUE.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
    req_addr = 32'h300; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("abort_wea_before", {28'd0, mem_data_wea}, 32'hF);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_wea", {28'd0, mem_data_wea}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_addr", mem_data_addr, 32'h0);
    chk("abort_rdata", rsp_rdata, 32'h0);
    rc0 = rsp_count;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_rsp", rsp_count, rc0);
    chk("abort_ready_after", {31'd0, req_ready}, 32'd1);
    req(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h0, 2'b00, 4'b0000, 32'h0, 2);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    chk("rsp_total", rsp_count, push_count);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
